// File: rtl/vending_pkg.sv
// Shared state codes, drink-code constants and price-table lookup for the
// parametrised vending controller.
package vending_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_COLLECT  = 2'd1;
    localparam state_t ST_DISPENSE = 2'd2;
    localparam state_t ST_REFUND   = 2'd3;

    localparam int DRINK_NONE  = 0;
    localparam int PRICE_TBL_W = 1024;

    // Extracts entry idx of a packed table of w-bit fields, zero-extended.
    function automatic logic [31:0] price_lookup(input logic [PRICE_TBL_W-1:0] tbl,
                                                 input int idx,
                                                 input int w);
        logic [31:0] p;
        logic [9:0]  pos;
        p   = '0;
        pos = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < w) begin
                pos      = 10'(idx * w + b);
                p[b[4:0]] = tbl[pos];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/vending_stock_bank.sv
// Per-drink stock counters: bulk reload, decrement by index, empty flags.
module vending_stock_bank
    import vending_pkg::*;
#(
    parameter int NUM_DRINKS = 4,
    parameter int DRINK_W    = $clog2(NUM_DRINKS),
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reload,
    input  logic                  dec,
    input  logic [DRINK_W-1:0]    dec_idx,
    output logic [NUM_DRINKS-1:0] empty
);

    logic [NUM_DRINKS-1:0][STOCK_W-1:0] cnt;

    for (genvar g = 0; g < NUM_DRINKS; g++) begin : g_cnt
        // Reload wins over a same-cycle decrement.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt[g] <= STOCK_W'(STOCK_INIT);
            else if (reload)
                cnt[g] <= STOCK_W'(STOCK_INIT);
            else if (dec && dec_idx == DRINK_W'(g) && cnt[g] != '0)
                cnt[g] <= cnt[g] - 1'b1;
        end

        assign empty[g] = (cnt[g] == '0);
    end

endmodule

// File: rtl/vending_ctrl_param.sv
// Multi-coin, N-drink vending controller: credit accumulation, price/stock
// checks, dispense with change, cancel and inactivity refunds.
module vending_ctrl_param
    import vending_pkg::*;
#(
    parameter int                              MONEY_W     = 8,
    parameter int                              NUM_DRINKS  = 4,
    parameter int                              DRINK_W     = $clog2(NUM_DRINKS),
    parameter logic [NUM_DRINKS*MONEY_W-1:0]   PRICES      = {8'd15, 8'd20, 8'd30, 8'd0},
    parameter int                              MAX_CREDIT  = 100,
    parameter int                              STOCK_W     = 4,
    parameter int                              STOCK_INIT  = 3,
    parameter int                              TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coin_valid_i,
    input  logic [MONEY_W-1:0]    coin_i,
    input  logic                  select_valid_i,
    input  logic [DRINK_W-1:0]    select_i,
    input  logic                  cancel_i,
    input  logic                  restock_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DRINK_W-1:0]    drink_o,
    output logic [MONEY_W-1:0]    change_o,
    output logic                  reject_o,
    output logic                  short_o,
    output logic                  empty_o,
    output logic [NUM_DRINKS-1:0] stock_empty_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t               state, state_n;
    logic [MONEY_W-1:0]   credit, credit_n;
    logic [MONEY_W-1:0]   chg_q, chg_n;
    logic [DRINK_W-1:0]   sel_q, sel_n;
    logic [TMR_W-1:0]     tmr, tmr_n;
    logic                 rej_n, short_n, empty_n;
    logic                 dec, reload;
    logic [MONEY_W:0]     sum;
    logic [MONEY_W-1:0]   price;
    logic                 sel_bad;
    logic [NUM_DRINKS-1:0] empty_flags;

    assign sum     = {1'b0, credit} + {1'b0, coin_i};
    assign price   = MONEY_W'(price_lookup(PRICE_TBL_W'(PRICES), int'(select_i), MONEY_W));
    assign sel_bad = (select_i == DRINK_W'(DRINK_NONE)) || (int'(select_i) >= NUM_DRINKS);

    vending_stock_bank #(
        .NUM_DRINKS (NUM_DRINKS),
        .DRINK_W    (DRINK_W),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk     (clk),
        .reset   (reset),
        .reload  (reload),
        .dec     (dec),
        .dec_idx (select_i),
        .empty   (empty_flags)
    );

    assign stock_empty_o = empty_flags;

    always_comb begin
        state_n  = state;
        credit_n = credit;
        chg_n    = chg_q;
        sel_n    = sel_q;
        tmr_n    = tmr;
        rej_n    = 1'b0;
        short_n  = 1'b0;
        empty_n  = 1'b0;
        dec      = 1'b0;
        reload   = 1'b0;

        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (state == ST_COLLECT)
                    tmr_n = tmr + 1'b1;

                // cancel > select > coin; a coin losing arbitration is refused
                if (cancel_i) begin
                    rej_n = coin_valid_i;
                    if (state == ST_COLLECT) begin
                        state_n  = ST_REFUND;
                        sel_n    = DRINK_W'(DRINK_NONE);
                        chg_n    = credit;
                        credit_n = '0;
                    end
                end else if (select_valid_i) begin
                    rej_n = coin_valid_i;
                    if (sel_bad) begin
                        if (state == ST_COLLECT) begin
                            state_n  = ST_REFUND;
                            sel_n    = DRINK_W'(DRINK_NONE);
                            chg_n    = credit;
                            credit_n = '0;
                        end
                    end else if (empty_flags[select_i]) begin
                        empty_n = 1'b1;
                    end else if (price == '0 || credit < price) begin
                        short_n = 1'b1;
                    end else begin
                        state_n  = ST_DISPENSE;
                        sel_n    = select_i;
                        chg_n    = credit - price;
                        credit_n = '0;
                        dec      = 1'b1;
                    end
                end else if (coin_valid_i) begin
                    if (sum > (MONEY_W+1)'(MAX_CREDIT)) begin
                        rej_n = 1'b1;
                    end else if (coin_i != '0) begin
                        credit_n = sum[MONEY_W-1:0];
                        state_n  = ST_COLLECT;
                        tmr_n    = '0;
                    end else if (state == ST_COLLECT) begin
                        tmr_n = '0;
                    end
                end

                if (state == ST_COLLECT && state_n == ST_COLLECT &&
                    tmr_n == TMR_W'(TIMEOUT_CYC)) begin
                    state_n  = ST_REFUND;
                    sel_n    = DRINK_W'(DRINK_NONE);
                    chg_n    = credit_n;
                    credit_n = '0;
                end

                if (state == ST_IDLE && restock_i)
                    reload = 1'b1;
            end
            default: begin
                rej_n   = coin_valid_i;
                state_n = ST_IDLE;
                tmr_n   = '0;
            end
        endcase
    end

    // Handshake outputs lag the state by one edge so done_o spans the cycle
    // after the dispense/refund state is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            credit   <= '0;
            chg_q    <= '0;
            sel_q    <= '0;
            tmr      <= '0;
            ready_o  <= 1'b1;
            done_o   <= 1'b0;
            drink_o  <= '0;
            change_o <= '0;
            reject_o <= 1'b0;
            short_o  <= 1'b0;
            empty_o  <= 1'b0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            chg_q    <= chg_n;
            sel_q    <= sel_n;
            tmr      <= tmr_n;
            ready_o  <= (state == ST_IDLE) || (state == ST_COLLECT);
            done_o   <= (state == ST_DISPENSE) || (state == ST_REFUND);
            drink_o  <= (state == ST_DISPENSE) ? sel_q : '0;
            change_o <= (state == ST_DISPENSE || state == ST_REFUND) ? chg_q : '0;
            reject_o <= rej_n;
            short_o  <= short_n;
            empty_o  <= empty_n;
        end
    end

endmodule

// File: doc/vending_ctrl_param.md
# vending_ctrl_param

Parametrised drink-vending controller: accumulates multiple coin insertions into a credit register, checks a drink selection against a parameter price table and per-drink stock counters, and dispenses with change, refunds on cancel, or refunds on inactivity timeout. It is the multi-coin, N-product generation of the team's single-shot vending FSM and feeds the dispenser/display logic through registered outputs.

## Interface
- MONEY_W, 8, width of coin, credit, price and change values
- NUM_DRINKS, 4, number of drink codes including code 0 (= "no drink")
- DRINK_W, $clog2(NUM_DRINKS), drink code width
- PRICES, {8'd15,8'd20,8'd30,8'd0}, packed NUM_DRINKS*MONEY_W price table, entry i at bits [i*MONEY_W +: MONEY_W]
- MAX_CREDIT, 100, highest credit accepted
- STOCK_W, 4, stock counter width
- STOCK_INIT, 3, per-drink stock after reset or restock
- TIMEOUT_CYC, 16, idle cycles in COLLECT before auto-refund
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- coin_valid_i  in  1  coin present this cycle
- coin_i  in  MONEY_W  coin value
- select_valid_i  in  1  selection present this cycle
- select_i  in  DRINK_W  requested drink code
- cancel_i  in  1  refund request
- restock_i  in  1  reload all stock counters
- ready_o  out  1  controller accepting coins/selections
- done_o  out  1  one-cycle transaction-complete pulse
- drink_o  out  DRINK_W  dispensed drink (0 = refund), valid with done_o
- change_o  out  MONEY_W  returned money, valid with done_o
- reject_o  out  1  one-cycle pulse: coin refused
- short_o  out  1  one-cycle pulse: credit below price
- empty_o  out  1  one-cycle pulse: selected drink out of stock
- stock_empty_o  out  NUM_DRINKS  bit i set when stock[i]==0

## Operation
- States: IDLE, COLLECT, DISPENSE, REFUND. All outputs registered.
- Per-cycle input priority in IDLE/COLLECT: cancel_i > select_valid_i > coin_valid_i. A lower-priority input in the same cycle is dropped; a dropped coin raises reject_o.
- Coin: credit+coin computed at MONEY_W+1 bits; if > MAX_CREDIT, reject_o, credit unchanged; else credit updated, IDLE->COLLECT, timeout counter cleared. coin_i==0 accepted as no-op (no state change from IDLE).
- Select in COLLECT: code 0 or code >= NUM_DRINKS treated as cancel. Else if stock[sel]==0: empty_o, stay. Else if credit < PRICES[sel]: short_o, stay. Else -> DISPENSE, change = credit-price, stock[sel] decremented, credit cleared.
- Select in IDLE (credit 0): evaluated identically; zero-price codes never dispense (code 0 is cancel → no-op in IDLE).
- Cancel in COLLECT -> REFUND with change = credit; in IDLE ignored.
- Timeout: counter increments each COLLECT cycle with no accepted coin; on reaching TIMEOUT_CYC -> REFUND.
- DISPENSE/REFUND last one cycle: done_o=1, drink_o=sel or 0, change_o set; next state IDLE. Inputs during these cycles ignored (coins raise reject_o).
- restock_i honoured only in IDLE; sets every stock counter to STOCK_INIT; otherwise ignored.
- drink_o/change_o are 0 whenever done_o is 0.

## Timing
- Reset: state IDLE, credit 0, all stock STOCK_INIT, ready_o=1, done_o=0, drink_o=0, change_o=0, reject_o/short_o/empty_o=0, stock_empty_o=0 (for STOCK_INIT>0).
- ready_o=1 in IDLE/COLLECT, 0 in DISPENSE/REFUND.
- Select sampled at edge k -> done_o high from edge k+1 to k+2; ready_o high again after edge k+2.
- Error pulses (reject/short/empty) appear the cycle after the offending sample, one cycle wide.
- Timeout refund: done_o rises TIMEOUT_CYC+1 edges after last accepted coin.
- Reset mid-transaction discards credit without refund and reloads stock.

## Structure
- Package vending_pkg: state enum, drink-code constant for "none" (0), price-lookup function over packed PRICES.
- Sub-module vending_stock_bank: NUM_DRINKS counters with decrement-by-index, bulk reload, and empty flags.

## Test plan
- Coins 10,10,10 then select 1 -> done_o with drink_o=1, change_o=0; stock[1]=2.
- Coins 50 then select 3 -> drink_o=3, change_o=35.
- Coins 90 then coin 20 -> reject_o, credit stays 90; cancel -> drink_o=0, change_o=90.
- Coin 10, select 1 -> short_o, stay COLLECT; idle 16 cycles -> done_o, drink_o=0, change_o=10.
- Buy drink 2 three times (coin 20 each) -> stock_empty_o[2]=1; fourth attempt -> empty_o; restock in IDLE clears flag.
- Coin 30 and select 1 same cycle -> reject_o, short_o; reset during COLLECT -> all outputs at reset values, no done_o.
